// File: rtl/regfile_pkg.sv
// Shared RV32I integer register file constants: geometry and the hardwired-zero index.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

endpackage

// File: rtl/regfile_decoder.sv
// Write-port address decoder: one-hot write enables, gated by the write strobe, x0 never enabled.
module decoder_5to32
  import regfile_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  en_i,
  output logic [NUM_REGS-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
    onehot_o[X0_IDX] = 1'b0;
  end

endmodule

// File: rtl/regfile.sv
// RV32I register file: two combinational read ports, one clocked write port, x0 reads zero.
module regfile #(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0]                  rd_data_i,
  input  logic                               rd_wren_i,
  output logic [DATA_W-1:0]                  rs1_data_o,
  output logic [DATA_W-1:0]                  rs2_data_o
);
  import regfile_pkg::*;

  logic [regfile_pkg::NUM_REGS-1:0]  wr_en;
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;

  decoder_5to32 u_dec (
    .addr_i   (rd_addr_i),
    .en_i     (rd_wren_i),
    .onehot_o (wr_en)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < int'(NUM_REGS); i++)
      if (wr_en[i]) regs_d[i] = rd_data_i;
  end

  // x0 keeps a flop slot but the decoder never enables it, so it is constant zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  // Two independent read muxes straight off the array; no write bypass.
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rs1_addr_i == REG_ADDR_W'(i)) rs1_data_o = regs_q[i];
      if (rs2_addr_i == REG_ADDR_W'(i)) rs2_data_o = regs_q[i];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: driver pushes expected reads from an array model, negedge monitor compares.
module tb_regfile;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0;
  logic [31:0] rs1_o, rs2_o;

  exp_t        q[$];
  logic [31:0] model [32];
  int          vecs = 0;
  int          miss = 0;
  bit          drv_done = 1'b0;

  regfile dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rd_addr_i  (rd),
    .rd_data_i  (wd),
    .rd_wren_i  (we),
    .rs1_data_o (rs1_o),
    .rs2_data_o (rs2_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdm(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  // One cycle of stimulus: inputs change just after the rising edge and hold until the next.
  task automatic cyc(input bit r, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] wa, input logic [31:0] d, input bit w, input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst = r; rs1 = a1; rs2 = a2; rd = wa; wd = d; we = w;
    if (r) for (int i = 0; i < 32; i++) model[i] = 32'd0;
    e.e1 = rdm(a1);
    e.e2 = rdm(a2);
    e.nm = nm;
    q.push_back(e);
    if (!r && w && wa != 5'd0) model[wa] = d;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vecs++;
      if (rs1_o !== e.e1 || rs2_o !== e.e2) begin
        miss++;
        $display("FAIL %s: rs1 got %h want %h, rs2 got %h want %h", e.nm, rs1_o, e.e1, rs2_o, e.e2);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    for (int i = 0; i < 3; i++)
      cyc(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b1, "reset_hold");
    for (int i = 0; i < 32; i++)
      cyc(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'd0, 1'b0, "reset_sweep");

    cyc(1'b0, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1, "wr_x5");
    cyc(1'b0, 5'd5, 5'd5, 5'd0, 32'd0, 1'b0, "rd_x5_both");

    cyc(1'b0, 5'd0, 5'd5, 5'd0, 32'hFFFFFFFF, 1'b1, "wr_x0");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, "rd_x0");

    cyc(1'b0, 5'd0, 5'd0, 5'd7, 32'h1, 1'b1, "wr_x7_1");
    cyc(1'b0, 5'd7, 5'd7, 5'd7, 32'h2, 1'b1, "x7_no_bypass");
    cyc(1'b0, 5'd7, 5'd0, 5'd0, 32'd0, 1'b0, "x7_after_edge");

    cyc(1'b0, 5'd0, 5'd0, 5'd3, 32'hA5A5A5A5, 1'b1, "wr_x3");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 5'd3, 5'd7, 5'd3, 32'd0, 1'b0, "x3_hold");
    cyc(1'b0, 5'd3, 5'd5, 5'd0, 32'd0, 1'b0, "x3_final");

    cyc(1'b0, 5'd0, 5'd0, 5'd9, 32'h11111111, 1'b1, "wr_x9_a");
    cyc(1'b0, 5'd9, 5'd0, 5'd9, 32'h22222222, 1'b1, "wr_x9_b");
    cyc(1'b0, 5'd9, 5'd9, 5'd0, 32'd0, 1'b0, "x9_last_wins");

    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 49) == 0), 5'($urandom), 5'($urandom), 5'($urandom),
          $urandom, 1'($urandom), "random");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, "random_tail");

    cyc(1'b0, 5'd0, 5'd0, 5'd31, 32'h12345678, 1'b1, "wr_x31");
    cyc(1'b0, 5'd31, 5'd3, 5'd0, 32'd0, 1'b0, "x31_written");
    cyc(1'b1, 5'd31, 5'd9, 5'd31, 32'hCAFEF00D, 1'b1, "x31_in_reset");
    cyc(1'b0, 5'd31, 5'd3, 5'd0, 32'd0, 1'b0, "x31_after_reset");
    cyc(1'b0, 5'd0, 5'd0, 5'd4, 32'h0BADF00D, 1'b1, "wr_first_after_rst");
    cyc(1'b0, 5'd4, 5'd31, 5'd0, 32'd0, 1'b0, "x4_first_after_rst");

    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!drv_done && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    if (!drv_done || q.size() != 0) begin
      miss++;
      $display("FAIL drain: driver_done=%0d pending=%0d want done=1 pending=0", drv_done, q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
